im_loader: RTL

//  Boot-time writer for the SISC instruction memory (im). Accepts a byte stream
//  (length header + big-endian 32-bit instruction words) over a valid/ready

---
 rtl/im_loader.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/im_loader.sv
// im_loader: boot-time writer that streams a length-prefixed, big-endian image into im.
// Define CHECKSUM_EN to add a trailing XOR checksum byte and the sticky err flag.
module im_loader #(
    parameter int unsigned       ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    typedef enum logic [2:0] {StIdle, StLenHi, StLenLo, StData, StCsum, StDone} state_e;

    state_e      state_q;
    logic [7:0]  len_hi_q;
    logic [15:0] words_left_q;
    logic [1:0]  byte_idx_q;
    logic        xfer;
    logic [15:0] len_word;

    assign xfer     = in_valid & in_ready;
    assign len_word = {len_hi_q, in_data};

`ifdef CHECKSUM_EN
    logic [7:0] csum_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            state_q      <= StIdle;
            len_hi_q     <= 8'h00;
            words_left_q <= 16'h0000;
            byte_idx_q   <= 2'd0;
            in_ready     <= 1'b0;
            im_we        <= 1'b0;
            im_addr      <= BASE_ADDR;
            im_wdata     <= 32'h0000_0000;
            busy         <= 1'b0;
            done         <= 1'b0;
            cpu_hold     <= 1'b1;
`ifdef CHECKSUM_EN
            csum_q       <= 8'h00;
            err          <= 1'b0;
`endif
        end else begin
            im_we <= 1'b0;
            // Address advances the cycle after each write strobe, so im_addr is the
            // target while im_we is high.
            if (im_we) begin
                im_addr <= im_addr + ADDR_W'(1);
            end
`ifdef CHECKSUM_EN
            // Every accepted byte except the checksum itself folds into the running XOR.
            if (xfer && state_q != StCsum) begin
                csum_q <= csum_q ^ in_data;
            end
`endif
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q    <= StLenHi;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        cpu_hold   <= 1'b1;
                        im_addr    <= BASE_ADDR;
                        byte_idx_q <= 2'd0;
`ifdef CHECKSUM_EN
                        csum_q     <= 8'h00;
                        err        <= 1'b0;
`endif
                    end
                end
                StLenHi: begin
                    if (xfer) begin
                        len_hi_q <= in_data;
                        state_q  <= StLenLo;
                    end
                end
                StLenLo: begin
                    if (xfer) begin
                        words_left_q <= len_word;
                        byte_idx_q   <= 2'd0;
                        if (len_word == 16'h0000) begin
`ifdef CHECKSUM_EN
                            state_q  <= StCsum;
`else
                            state_q  <= StDone;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
`endif
                        end else begin
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (xfer) begin
                        unique case (byte_idx_q)
                            2'd0: im_wdata[31:24] <= in_data;
                            2'd1: im_wdata[23:16] <= in_data;
                            2'd2: im_wdata[15:8]  <= in_data;
                            2'd3: im_wdata[7:0]   <= in_data;
                            default: ;
                        endcase
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            im_we        <= 1'b1;
                            words_left_q <= words_left_q - 16'd1;
                            if (words_left_q == 16'd1) begin
`ifdef CHECKSUM_EN
                                state_q  <= StCsum;
`else
                                state_q  <= StDone;
                                in_ready <= 1'b0;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                cpu_hold <= 1'b0;
`endif
                            end
                        end
                    end
                end
`ifdef CHECKSUM_EN
                StCsum: begin
                    if (xfer) begin
                        state_q  <= StDone;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        err      <= (in_data != csum_q);
                        cpu_hold <= (in_data != csum_q);
                    end
                end
`endif
                default: begin
                    state_q  <= StIdle;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
